// File: rtl/execute_block_pkg.sv
// Shared encodings for the EX stage: opcodes, forwarding selects, flag bit positions, FSM states.
package execute_block_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOT  = 5'd5;
  localparam logic [4:0] OP_SLL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_INC  = 5'd9;
  localparam logic [4:0] OP_DEC  = 5'd10;
  localparam logic [4:0] OP_PASS = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd12;

  localparam logic [1:0] FWD_ID = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_DM = 2'd2;
  localparam logic [1:0] FWD_WB = 2'd3;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic mem_rw;
    logic mem_en;
    logic mem_mux_sel;
    logic flag_en;
  } ctrl_t;

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/execute_block_mul.sv
// Shift-add multiplier: start loads operands, each step retires one multiplier bit.
// done pulses during the final step, with product showing the value that step produces.
module seq_multiplier #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_sum;

  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done    = step && (cnt_q == LAST);
  assign product = acc_sum;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/execute_block.sv
// EX stage: forwarding muxes, single-cycle ALU, and a sequential multiply that stalls decode.
// ALU ops register in 1 cycle; MUL lands 17 edges after accept with stall_ex high for 16 cycles.
module execute_block
  import execute_block_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A_id,
  input  logic [WIDTH-1:0] B_id,
  input  logic [WIDTH-1:0] imm_id,
  input  logic             imm_sel_id,
  input  logic [4:0]       op_id,
  input  logic [1:0]       fwd_sel_a,
  input  logic [1:0]       fwd_sel_b,
  input  logic [WIDTH-1:0] ans_dm,
  input  logic [WIDTH-1:0] ans_wb,
  input  logic             mem_rw_id,
  input  logic             mem_en_id,
  input  logic             mem_mux_sel_id,
  input  logic             flag_en_id,
  output logic [WIDTH-1:0] ans_ex,
  output logic [WIDTH-1:0] DM_data,
  output logic             mem_rw_ex,
  output logic             mem_en_ex,
  output logic             mem_mux_sel_ex,
  output logic [3:0]       flags_ex,
  output logic             stall_ex
);

  localparam int SW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ans_q, ans_d, dm_q, dm_d, dm_lat_q, dm_lat_d;
  logic             mem_rw_q, mem_rw_d, mem_en_q, mem_en_d, mux_q, mux_d;
  logic [3:0]       flags_q, flags_d;
  ctrl_t            ctrl_lat_q, ctrl_lat_d;

  logic [WIDTH-1:0] op_a, bf, op_b, arith_b, alu_res, mul_prod;
  logic [WIDTH:0]   add_r, sub_r;
  logic             add_v, sub_v, alu_c, alu_v, mul_start, mul_step, mul_done;
  logic [SW-1:0]    shamt;

  always_comb begin
    unique case (fwd_sel_a)
      FWD_EX:  op_a = ans_q;
      FWD_DM:  op_a = ans_dm;
      FWD_WB:  op_a = ans_wb;
      default: op_a = A_id;
    endcase
    unique case (fwd_sel_b)
      FWD_EX:  bf = ans_q;
      FWD_DM:  bf = ans_dm;
      FWD_WB:  bf = ans_wb;
      default: bf = B_id;
    endcase
  end

  assign op_b    = imm_sel_id ? imm_id : bf;
  assign shamt   = op_b[SW-1:0];
  // INC/DEC reuse the adder/subtractor so carry/borrow and overflow come for free.
  assign arith_b = (op_id == OP_INC || op_id == OP_DEC) ? WIDTH'(1) : op_b;
  assign add_r   = {1'b0, op_a} + {1'b0, arith_b};
  assign sub_r   = {1'b0, op_a} - {1'b0, arith_b};
  assign add_v   = (op_a[WIDTH-1] == arith_b[WIDTH-1]) && (add_r[WIDTH-1] != op_a[WIDTH-1]);
  assign sub_v   = (op_a[WIDTH-1] != arith_b[WIDTH-1]) && (sub_r[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_id)
      OP_ADD, OP_INC: begin alu_res = add_r[WIDTH-1:0]; alu_c = add_r[WIDTH]; alu_v = add_v; end
      OP_SUB, OP_DEC: begin alu_res = sub_r[WIDTH-1:0]; alu_c = sub_r[WIDTH]; alu_v = sub_v; end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOT:  alu_res = ~op_a;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      OP_SRL:  alu_res = op_a >> shamt;
      OP_PASS: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign mul_step = (state_q == ST_MUL_BUSY);

  seq_multiplier #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .step    (mul_step),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d    = state_q;
    ans_d      = ans_q;
    dm_d       = dm_q;
    mem_rw_d   = mem_rw_q;
    mem_en_d   = mem_en_q;
    mux_d      = mux_q;
    flags_d    = flags_q;
    ctrl_lat_d = ctrl_lat_q;
    dm_lat_d   = dm_lat_q;
    mul_start  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (op_id == OP_MUL) begin
        mul_start  = 1'b1;
        ctrl_lat_d = '{mem_rw: mem_rw_id, mem_en: mem_en_id,
                       mem_mux_sel: mem_mux_sel_id, flag_en: flag_en_id};
        dm_lat_d   = bf;
        mem_en_d   = 1'b0;
        mem_rw_d   = 1'b0;
        state_d    = ST_MUL_BUSY;
      end else begin
        ans_d    = alu_res;
        dm_d     = bf;
        mem_rw_d = mem_rw_id;
        mem_en_d = mem_en_id;
        mux_d    = mem_mux_sel_id;
        if (flag_en_id)
          flags_d = pack_flags(alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v);
      end
    end else begin
      mem_en_d = 1'b0;
      mem_rw_d = 1'b0;
      if (mul_done) begin
        ans_d    = mul_prod;
        dm_d     = dm_lat_q;
        mem_rw_d = ctrl_lat_q.mem_rw;
        mem_en_d = ctrl_lat_q.mem_en;
        mux_d    = ctrl_lat_q.mem_mux_sel;
        if (ctrl_lat_q.flag_en)
          flags_d = pack_flags(mul_prod == '0, mul_prod[WIDTH-1], 1'b0, 1'b0);
        state_d  = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ans_q      <= '0;
      dm_q       <= '0;
      mem_rw_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mux_q      <= 1'b0;
      flags_q    <= '0;
      ctrl_lat_q <= '0;
      dm_lat_q   <= '0;
    end else begin
      state_q    <= state_d;
      ans_q      <= ans_d;
      dm_q       <= dm_d;
      mem_rw_q   <= mem_rw_d;
      mem_en_q   <= mem_en_d;
      mux_q      <= mux_d;
      flags_q    <= flags_d;
      ctrl_lat_q <= ctrl_lat_d;
      dm_lat_q   <= dm_lat_d;
    end
  end

  assign ans_ex         = ans_q;
  assign DM_data        = dm_q;
  assign mem_rw_ex      = mem_rw_q;
  assign mem_en_ex      = mem_en_q;
  assign mem_mux_sel_ex = mux_q;
  assign flags_ex       = flags_q;
  assign stall_ex       = (state_q == ST_MUL_BUSY);

endmodule

// File: doc/execute_block.md
Name: execute_block

Overview:
- EX stage of the 16-bit MIPS pipeline, directly upstream of the data-memory stage.
- Resolves operand forwarding and performs ALU operations, including a 16-cycle multi-cycle multiply.
- Registers ans_ex, DM_data and the memory controls that the data-memory stage consumes.
- Raises stall_ex toward decode while a multiply is in progress.

Parameters:
- WIDTH, 16, datapath width.
- MUL_CYCLES, 16, shift-add steps per multiply; equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- A_id  in  16  operand A from register read
- B_id  in  16  operand B / store data from register read
- imm_id  in  16  sign-extended immediate
- imm_sel_id  in  1  1: ALU B input = imm_id
- op_id  in  5  ALU opcode
- fwd_sel_a  in  2  source of A: 0 A_id, 1 ans_ex, 2 ans_dm, 3 ans_wb
- fwd_sel_b  in  2  same encoding, for B
- ans_dm  in  16  data-memory stage result (forwarding)
- ans_wb  in  16  write-back result (forwarding)
- mem_rw_id  in  1  1 = write
- mem_en_id  in  1  memory enable
- mem_mux_sel_id  in  1  1 = write-back takes memory data
- flag_en_id  in  1  update flag register
- ans_ex  out  16  registered ALU result / memory address
- DM_data  out  16  registered store data
- mem_rw_ex  out  1  registered mem_rw_id
- mem_en_ex  out  1  registered mem_en_id
- mem_mux_sel_ex  out  1  registered mem_mux_sel_id
- flags_ex  out  4  {Z,N,C,V}
- stall_ex  out  1  multiply busy; decode holds its outputs

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM to IDLE, multiply counter 0. A reset mid-multiply aborts it and produces no result.
- Operand A = mux(fwd_sel_a); Bf = mux(fwd_sel_b); operand B = imm_sel_id ? imm_id : Bf.
- DM_data <= Bf, so store data is forwarded even when imm_sel_id=1.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A
  - 6 SLL by B[3:0], 7 SRA by B[3:0], 8 SRL by B[3:0]
  - 9 INC A, 10 DEC A, 11 PASS B, 12 MUL (low 16 bits of unsigned product)
  - 13-31: result 0.
- Flags, updated only when flag_en_id=1, on the edge that writes ans_ex:
  - Z = (result==0); N = result[15].
  - C = carry out for ADD/INC; borrow (A<B unsigned) for SUB/DEC; 0 otherwise.
  - V = signed overflow for ADD/SUB/INC/DEC; 0 otherwise.
- FSM IDLE:
  - Non-MUL op: single-cycle; result and all controls registered on the next edge.
  - op=12: latch A, B and the controls; go to MUL_BUSY with cnt=0.
  - The accept edge registers a bubble: mem_en_ex=0, mem_rw_ex=0; ans_ex/DM_data hold.
- FSM MUL_BUSY:
  - stall_ex=1, a combinational decode of state; exactly 16 cycles.
  - Each edge: if multiplier bit 0 is set, add the shifted multiplicand to the accumulator; shift; cnt++.
  - Edge with cnt==15: ans_ex <= product[15:0], latched controls and DM_data registered, flags updated if latched flag_en; back to IDLE.
  - Intermediate busy edges keep the bubble.
  - All *_id inputs are ignored while busy.
- Latency:
  - ALU op: 1 cycle.
  - MUL: result visible after the 17th edge counted from the accept edge; stall_ex high for 16 cycles.
- Wrap-around: ADD/SUB/INC/DEC wrap modulo 2^16.
- Shifts: amount 0 passes A unchanged; SRA replicates bit 15.
- Forwarding with fwd_sel=1 uses the current (pre-edge) ans_ex value.

Decomposition:
- Shared package: opcode constants (OP_ADD..OP_MUL), forwarding-select encodings, flag bit indices, FSM state encodings.
- One natural sub-module, seq_multiplier: start/busy/done interface, 16-step shift-add datapath and counter.
- ALU and forwarding muxes stay combinational inside execute_block.

Test Plan:
- Reset and ADD:
  - Hold reset=0 -> all outputs 0.
  - Release; A_id=0x0003, imm_id=0x0004, imm_sel=1, op=ADD, mem_en=1, mem_rw=1, B_id=0xFFFF -> next edge: ans_ex=0x0007, DM_data=0xFFFF, mem_en_ex=1, mem_rw_ex=1.
- Flags:
  - ADD 0x7FFF+0x0001, flag_en=1 -> ans_ex=0x8000, flags={0,1,0,1}.
  - SUB 0x0001-0x0001 -> 0x0000, flags={1,0,0,0}.
  - SUB 0x0000-0x0001 -> 0xFFFF, C=1.
- Forwarding:
  - ans_dm=0x1234, ans_wb=0x00FF, fwd_sel_a=2, fwd_sel_b=3, op=AND -> ans_ex=0x0034.
  - Back-to-back INC with fwd_sel_a=1 from 0x0005 -> 0x0006, then 0x0007.
- Multiply:
  - A=0x0012, B=0x0034, op=MUL -> stall_ex high for exactly 16 cycles; mem_en_ex=0 during the bubble.
  - ans_ex=0x03A8 after the 17th edge.
  - 0xFFFF*0x0002 -> 0xFFFE.
- Reset mid-multiply:
  - Assert reset at busy cycle 7 -> stall_ex=0 and ans_ex=0 immediately.
  - Next ADD 1+1 -> 0x0002 one cycle later.
- Shifts and illegal opcodes:
  - SRA 0x8000 by 4 -> 0xF800; SRL 0x8000 by 4 -> 0x0800; SLL by 0 -> A unchanged.
  - op=20 -> ans_ex=0x0000.
